// File: rtl/sub_clk_ratio_monitor_if.sv
// Result bus of sub_clk_ratio_monitor: sampled fastclk in, counters and ratio out.
// ratio_valid qualifies ratio and is sticky until reset; there is no ready, the sink samples at will.
interface sub_clk_ratio_monitor_if #(
  parameter int CNT_W = 32
);
  logic             fastclk;
  logic [CNT_W-1:0] clk_count;
  logic [CNT_W-1:0] fast_count;
  logic [CNT_W-1:0] ratio;
  logic             ratio_valid;
  logic             busy;
  logic [1:0]       state_dbg;

  modport master (
    output fastclk,
    input  clk_count, fast_count, ratio, ratio_valid, busy, state_dbg
  );

  modport slave (
    input  fastclk,
    output clk_count, fast_count, ratio, ratio_valid, busy, state_dbg
  );
endinterface

// File: rtl/sub_clk_ratio_monitor.sv
// Counts clk cycles and synchronised fastclk rising edges over a fixed window, then divides.
// Define SUB_DISPLAY_EN to print the ratio and end simulation when the result is ready.
module sub_clk_ratio_monitor #(
  parameter int          CNT_W        = 32,
  parameter int unsigned FINISH_COUNT = 3
) (
  input  logic                    clk,
  input  logic                    reset_l,
  sub_clk_ratio_monitor_if.slave  bus
);

  localparam int               STEP_W     = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(CNT_W - 1);
  localparam logic [CNT_W-1:0]  FINISH_VAL = CNT_W'(FINISH_COUNT);

  typedef enum logic [1:0] {
    ST_COUNT  = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [2:0]          r_sync;
  logic                w_edge;
  logic [CNT_W-1:0]    r_clk_count;
  logic [CNT_W-1:0]    r_fast_count;
  logic [CNT_W-1:0]    r_quo;
  logic [CNT_W-1:0]    r_rem;
  logic [STEP_W-1:0]   r_step;
  logic [CNT_W-1:0]    r_ratio;
  logic                r_ratio_valid;
  logic [CNT_W:0]      w_rem_shift;
  logic [CNT_W:0]      w_rem_next;
  logic                w_ge;
  logic [CNT_W-1:0]    w_quo_next;

  // sync[1] is the second synchroniser stage, sync[2] its delayed copy for edge detect
  assign w_edge = r_sync[1] & ~r_sync[2];

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= ST_COUNT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_COUNT:  if (r_clk_count == FINISH_VAL) w_next_state = ST_DIVIDE;
      ST_DIVIDE: if (r_step == LAST_STEP) w_next_state = ST_DONE;
      ST_DONE:   w_next_state = ST_DONE;
      default:   w_next_state = ST_COUNT;
    endcase
  end

  // Restoring divider step: dividend shifts out of r_quo while quotient bits shift in
  always_comb begin
    w_rem_shift = {r_rem, r_quo[CNT_W-1]};
    w_ge        = (w_rem_shift >= {1'b0, r_clk_count});
    w_rem_next  = w_ge ? (w_rem_shift - {1'b0, r_clk_count}) : w_rem_shift;
    w_quo_next  = {r_quo[CNT_W-2:0], w_ge};
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_sync        <= '0;
      r_clk_count   <= '0;
      r_fast_count  <= '0;
      r_quo         <= '0;
      r_rem         <= '0;
      r_step        <= '0;
      r_ratio       <= '0;
      r_ratio_valid <= 1'b0;
    end else begin
      r_sync <= {r_sync[1:0], bus.fastclk};
      case (r_state)
        ST_COUNT: begin
          // The window-closing edge freezes both counters; an edge seen here is lost
          if (w_next_state == ST_DIVIDE) begin
            r_quo  <= r_fast_count;
            r_rem  <= '0;
            r_step <= '0;
          end else begin
            r_clk_count <= r_clk_count + CNT_W'(1);
            if (w_edge && (r_fast_count != '1)) begin
              r_fast_count <= r_fast_count + CNT_W'(1);
            end
          end
        end
        ST_DIVIDE: begin
          r_quo  <= w_quo_next;
          r_rem  <= w_rem_next[CNT_W-1:0];
          r_step <= r_step + STEP_W'(1);
          if (r_step == LAST_STEP) begin
            r_ratio       <= w_quo_next;
            r_ratio_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SUB_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (reset_l && (r_state == ST_DIVIDE) && (w_next_state == ST_DONE)) begin
      $display("[%0t] fastclk is %0d times faster than clk", $time, w_quo_next);
      $write("*-* All Finished *-*\n");
      $finish;
    end
  end
`else
  // Synthesizable build: results are only visible on the ports.
`endif

  assign bus.clk_count   = r_clk_count;
  assign bus.fast_count  = r_fast_count;
  assign bus.ratio       = r_ratio;
  assign bus.ratio_valid = r_ratio_valid;
  assign bus.busy        = (r_state != ST_DONE);
  assign bus.state_dbg   = r_state;

endmodule

// File: tb/tb_sub_clk_ratio_monitor.sv
// Bench for sub_clk_ratio_monitor: three instances (default, 8-bit window 10, 8-bit window 4).
module tb_sub_clk_ratio_monitor;

  localparam int EXP_W = 2 + 8 + 32 * 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_n;
  logic [2:0] fclk;
  int         checks = 0;
  int         errors = 0;
  int         cyc [3];
  logic [2:0] val_d = '0;
  logic [EXP_W-1:0] exp_q [$];

  sub_clk_ratio_monitor_if #(.CNT_W(32)) if_a ();
  sub_clk_ratio_monitor_if #(.CNT_W(8))  if_b ();
  sub_clk_ratio_monitor_if #(.CNT_W(8))  if_c ();

  assign if_a.fastclk = fclk[0];
  assign if_b.fastclk = fclk[1];
  assign if_c.fastclk = fclk[2];

  sub_clk_ratio_monitor u_a (.clk(clk), .reset_l(rst_n[0]), .bus(if_a));
  sub_clk_ratio_monitor #(.CNT_W(8), .FINISH_COUNT(10)) u_b (.clk(clk), .reset_l(rst_n[1]), .bus(if_b));
  sub_clk_ratio_monitor #(.CNT_W(8), .FINISH_COUNT(4))  u_c (.clk(clk), .reset_l(rst_n[2]), .bus(if_c));

  wire [2:0][31:0] cc;
  wire [2:0][31:0] fc;
  wire [2:0][31:0] rt;
  wire [2:0]       val;
  wire [2:0]       bsy;

  assign cc[0] = if_a.clk_count;
  assign fc[0] = if_a.fast_count;
  assign rt[0] = if_a.ratio;
  assign cc[1] = {24'd0, if_b.clk_count};
  assign fc[1] = {24'd0, if_b.fast_count};
  assign rt[1] = {24'd0, if_b.ratio};
  assign cc[2] = {24'd0, if_c.clk_count};
  assign fc[2] = {24'd0, if_c.fast_count};
  assign rt[2] = {24'd0, if_c.ratio};
  assign val   = {if_c.ratio_valid, if_b.ratio_valid, if_a.ratio_valid};
  assign bsy   = {if_c.busy, if_b.busy, if_a.busy};

  // post-reset clk edge number per instance; edge 1 is the first edge after release
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n[i]) cyc[i] <= 0;
      else           cyc[i] <= cyc[i] + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int inst, input int edge_n, input int ccv, input int fcv, input int rv);
    logic [1:0]  inst_b;
    logic [7:0]  edge_b;
    inst_b = inst[1:0];
    edge_b = edge_n[7:0];
    exp_q.push_back({inst_b, edge_b, 32'(ccv), 32'(fcv), 32'(rv)});
  endtask

  // scoreboard monitor: every ratio_valid rise consumes one expectation
  always @(negedge clk) begin : monitor
    logic [EXP_W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      if (val[i] && !val_d[i]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected inst=%0d actual=result required=none", i);
        end else begin
          e = exp_q.pop_front();
          check("sb_inst",       32'(i),        {30'd0, e[105:104]});
          check("sb_valid_edge", 32'(cyc[i]),   {24'd0, e[103:96]});
          check("sb_clk_count",  cc[i],         e[95:64]);
          check("sb_fast_count", fc[i],         e[63:32]);
          check("sb_ratio",      rt[i],         e[31:0]);
          check("sb_busy_done",  {31'd0, bsy[i]}, 32'd0);
        end
      end
    end
    val_d <= val;
  end

  task automatic hold_reset(input int inst);
    @(negedge clk);
    rst_n[inst] = 1'b0;
    fclk[inst]  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // release reset, optionally toggle fastclk every clk, probe mid-divide, wait for result
  task automatic run_meas(input int inst, input bit toggle, input int probe, input int budget);
    int n;
    repeat (2) @(negedge clk);
    rst_n[inst] = 1'b1;
    fclk[inst]  = toggle;
    n = 0;
    while (!val[inst] && n < budget) begin
      @(negedge clk);
      n++;
      if (cyc[inst] == probe) begin
        check("div_ratio_zero", rt[inst], 32'd0);
        check("div_busy",       {31'd0, bsy[inst]}, 32'd1);
        check("div_not_valid",  {31'd0, val[inst]}, 32'd0);
      end
      if (toggle) fclk[inst] = ~fclk[inst];
    end
    if (!val[inst]) begin
      checks++;
      errors++;
      $display("FAIL timeout inst=%0d actual=no_valid required=valid within %0d cycles", inst, budget);
    end
  endtask

  initial begin
    rst_n = '0;
    fclk  = '0;
    repeat (2) @(negedge clk);
    check("rst_clk_count",  cc[0], 32'd0);
    check("rst_fast_count", fc[0], 32'd0);
    check("rst_ratio",      rt[0], 32'd0);
    check("rst_valid",      {31'd0, val[0]}, 32'd0);
    check("rst_busy",       {31'd0, bsy[0]}, 32'd1);

    // start a measurement, abort it asynchronously mid-window
    rst_n[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_abort_clk_count", cc[0], 32'd2);
    check("pre_abort_busy",      {31'd0, bsy[0]}, 32'd1);
    @(posedge clk);
    #2;
    rst_n[0] = 1'b0;
    #1;
    check("abort_clk_count",  cc[0], 32'd0);
    check("abort_fast_count", fc[0], 32'd0);
    check("abort_ratio",      rt[0], 32'd0);
    check("abort_valid",      {31'd0, val[0]}, 32'd0);
    check("abort_busy",       {31'd0, bsy[0]}, 32'd1);

    // idle input, defaults: result on edge 3+1+32
    push_exp(0, 36, 3, 0, 0);
    run_meas(0, 1'b0, 20, 60);
    repeat (4) begin
      @(negedge clk);
      fclk[0] = ~fclk[0];
    end
    @(negedge clk);
    check("hold_clk_count",  cc[0], 32'd3);
    check("hold_fast_count", fc[0], 32'd0);
    check("hold_valid",      {31'd0, val[0]}, 32'd1);
    check("hold_busy",       {31'd0, bsy[0]}, 32'd0);

    // fastclk high on odd edges: rises counted at edges 3,5,7,9; the one at edge 11 is dropped
    push_exp(1, 19, 10, 4, 0);
    run_meas(1, 1'b1, 15, 40);

    // divider through forced dividend: 13/4 and 255/4
    force u_c.r_fast_count = 8'd13;
    push_exp(2, 13, 4, 13, 3);
    run_meas(2, 1'b0, 8, 30);
    @(negedge clk);
    release u_c.r_fast_count;
    hold_reset(2);
    force u_c.r_fast_count = 8'd255;
    push_exp(2, 13, 4, 255, 63);
    run_meas(2, 1'b0, 8, 30);
    @(negedge clk);
    release u_c.r_fast_count;

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
